// File: rtl/gsau_wb_buffer_pkg.sv
// gsau_wb_buffer_pkg: shared sizes and entry types for the GSAU writeback buffer
package gsau_wb_buffer_pkg;
    localparam int WB_DEPTH  = 4;
    localparam int WB_DATA_W = 512;
    localparam int WB_DST_W  = 8;

    typedef logic [WB_DATA_W-1:0] vreg_t;
    typedef logic [WB_DST_W-1:0]  sb_vdst_t;

    typedef struct packed {
        vreg_t                data;
        logic [WB_DST_W-1:0]  vdst;
    } wb_entry_t;
endpackage

// File: rtl/gsau_wb_buffer_if.sv
// gsau_wb_buffer_if: GSAU writeback channel, register-file write port and scoreboard completion
interface gsau_wb_buffer_if
    import gsau_wb_buffer_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int DST_W  = WB_DST_W,
    parameter int DEPTH  = WB_DEPTH
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] psum;
    logic [DST_W-1:0]  wbdst;
    logic              wb_valid;
    logic              output_ready;
    logic              rf_wen;
    logic [DATA_W-1:0] rf_wdata;
    logic [DST_W-1:0]  rf_wdst;
    logic              rf_ready;
    logic              sb_done;
    logic [DST_W-1:0]  sb_done_vdst;
    logic [OCC_W-1:0]  occupancy;

    modport master (
        output psum, wbdst, wb_valid, rf_ready,
        input  output_ready, rf_wen, rf_wdata, rf_wdst, sb_done, sb_done_vdst, occupancy
    );

    modport slave (
        input  psum, wbdst, wb_valid, rf_ready,
        output output_ready, rf_wen, rf_wdata, rf_wdst, sb_done, sb_done_vdst, occupancy
    );
endinterface

// File: rtl/gsau_wb_buffer_sync_fifo.sv
// gsau_wb_buffer_sync_fifo: power-of-two circular FIFO; caller must not push when full or pop when empty
module gsau_wb_buffer_sync_fifo
    import gsau_wb_buffer_pkg::*;
#(
    parameter type T     = wb_entry_t,
    parameter int  DEPTH = WB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             push,
    input  logic             pop,
    input  T                 wdata,
    output T                 rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    T                 mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    assign full  = count == CNT_W'(DEPTH);
    assign empty = count == '0;
    // head reads as zero when empty so the write port shows clean data after reset
    assign rdata = empty ? '0 : mem[rd_ptr];

    // pointers wrap naturally at DEPTH; count nets out a simultaneous push and pop
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // storage needs no reset; unread slots are never observed
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/gsau_wb_buffer.sv
// gsau_wb_buffer: queues GSAU psums and drains them in order to the register file with scoreboard completion
module gsau_wb_buffer
    import gsau_wb_buffer_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int DATA_W = WB_DATA_W,
    parameter int DST_W  = WB_DST_W
) (
    input  logic            CLK,
    input  logic            nRST,
    gsau_wb_buffer_if.slave bus
);
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [DST_W-1:0]  vdst;
    } entry_t;

    entry_t in_entry;
    entry_t head;
    logic   full;
    logic   empty;
    logic   push;
    logic   pop;

    assign in_entry         = {bus.psum, bus.wbdst};
    assign bus.output_ready = !full;
    assign bus.rf_wen       = !empty;
    assign bus.rf_wdata     = head.data;
    assign bus.rf_wdst      = head.vdst;
    assign push             = bus.wb_valid && !full;
    assign pop              = !empty && bus.rf_ready;

    gsau_wb_buffer_sync_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .nRST  (nRST),
        .push  (push),
        .pop   (pop),
        .wdata (in_entry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (bus.occupancy)
    );

    // completion pulse one cycle after each retirement; vdst holds between pulses
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bus.sb_done      <= 1'b0;
            bus.sb_done_vdst <= '0;
        end else begin
            bus.sb_done <= pop;
            if (pop) bus.sb_done_vdst <= head.vdst;
        end
    end
endmodule

// File: tb/tb_gsau_wb_buffer.sv
// tb_gsau_wb_buffer: directed and randomized checks of the writeback buffer against a queue model
module tb_gsau_wb_buffer;
    import gsau_wb_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic CLK = 1'b0;
    logic nRST;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [511:0] md[$];
    logic [7:0]   mv[$];
    logic         exp_sbd;
    logic [7:0]   exp_sbv;
    logic [7:0]   wr_log[$];
    logic [7:0]   sb_log[$];
    logic [511:0] snap;

    always #5 CLK = ~CLK;

    gsau_wb_buffer_if #(.DATA_W(512), .DST_W(8), .DEPTH(DEPTH)) bus ();

    gsau_wb_buffer #(.DEPTH(DEPTH), .DATA_W(512), .DST_W(8)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic compare();
        check("output_ready", bus.output_ready, md.size() != DEPTH);
        check("rf_wen", bus.rf_wen, md.size() != 0);
        check("occupancy", bus.occupancy, md.size());
        if (md.size() != 0) begin
            check("rf_wdata", bus.rf_wdata, md[0]);
            check("rf_wdst", bus.rf_wdst, mv[0]);
        end
        check("sb_done", bus.sb_done, exp_sbd);
        check("sb_done_vdst", bus.sb_done_vdst, exp_sbv);
        if (bus.sb_done) sb_log.push_back(bus.sb_done_vdst);
    endtask

    // one cycle: check outputs, drive inputs, advance the model, move to next falling edge
    task automatic cyc(input logic v, input logic [511:0] d, input logic [7:0] dst, input logic rr);
        logic p_push;
        logic p_pop;
        compare();
        if (bus.rf_wen && rr) wr_log.push_back(bus.rf_wdst);
        bus.wb_valid = v;
        bus.psum     = d;
        bus.wbdst    = dst;
        bus.rf_ready = rr;
        p_pop  = md.size() != 0 && rr;
        p_push = v && md.size() != DEPTH;
        exp_sbd = p_pop;
        if (p_pop) begin
            exp_sbv = mv[0];
            void'(md.pop_front());
            void'(mv.pop_front());
        end
        if (p_push) begin
            md.push_back(d);
            mv.push_back(dst);
        end
        @(negedge CLK);
    endtask

    initial begin
        nRST         = 1'b0;
        bus.wb_valid = 1'b0;
        bus.psum     = '0;
        bus.wbdst    = '0;
        bus.rf_ready = 1'b0;
        exp_sbd      = 1'b0;
        exp_sbv      = '0;
        @(negedge CLK);
        compare();
        check("rst_wdata", bus.rf_wdata, '0);
        check("rst_wdst", bus.rf_wdst, '0);
        nRST = 1'b1;

        // single entry
        cyc(1'b1, {64{8'hA5}}, 8'h03, 1'b1);
        check("single_wen", bus.rf_wen, 1'b1);
        check("single_data", bus.rf_wdata, {64{8'hA5}});
        cyc(1'b0, '0, '0, 1'b1);
        check("single_sb", bus.sb_done, 1'b1);
        check("single_sbv", bus.sb_done_vdst, 8'h03);
        check("single_occ", bus.occupancy, 0);
        cyc(1'b0, '0, '0, 1'b1);

        // fill to full, blocked fifth offer, then drain in order
        wr_log.delete();
        sb_log.delete();
        for (int i = 1; i <= 4; i++) cyc(1'b1, rnd512(), 8'(i), 1'b0);
        check("full_ready", bus.output_ready, 1'b0);
        check("full_occ", bus.occupancy, 4);
        snap = rnd512();
        cyc(1'b1, snap, 8'h05, 1'b0);
        cyc(1'b1, snap, 8'h05, 1'b0);
        check("full_block_occ", bus.occupancy, 4);
        cyc(1'b1, snap, 8'h05, 1'b1);
        cyc(1'b1, snap, 8'h05, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b0, '0, '0, 1'b1);
        check("full_wr_cnt", wr_log.size(), 5);
        check("full_sb_cnt", sb_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check("full_wr_order", wr_log[i], i + 1);
            check("full_sb_order", sb_log[i], i + 1);
        end

        // push and pop together at full: only the pop happens, then steady state at 3
        for (int i = 0; i < 4; i++) cyc(1'b1, rnd512(), 8'(16 + i), 1'b0);
        cyc(1'b1, rnd512(), 8'h20, 1'b1);
        check("pp_occ", bus.occupancy, 3);
        check("pp_ready", bus.output_ready, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b1, rnd512(), 8'(8'h21 + i), 1'b1);
        check("pp_steady_occ", bus.occupancy, 3);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, '0, 1'b1);

        // register-file backpressure
        sb_log.delete();
        cyc(1'b1, rnd512(), 8'h41, 1'b0);
        cyc(1'b1, rnd512(), 8'h42, 1'b0);
        snap = bus.rf_wdata;
        cyc(1'b0, '0, '0, 1'b0);
        check("bp_stable0", bus.rf_wdata, snap);
        cyc(1'b0, '0, '0, 1'b1);
        snap = bus.rf_wdata;
        cyc(1'b0, '0, '0, 1'b0);
        check("bp_stable1", bus.rf_wdata, snap);
        cyc(1'b0, '0, '0, 1'b1);
        cyc(1'b0, '0, '0, 1'b1);
        cyc(1'b0, '0, '0, 1'b1);
        check("bp_sb_cnt", sb_log.size(), 2);
        check("bp_sb0", sb_log[0], 8'h41);
        check("bp_sb1", sb_log[1], 8'h42);

        // asynchronous reset with entries queued
        for (int i = 0; i < 3; i++) cyc(1'b1, rnd512(), 8'(8'h30 + i), 1'b0);
        compare();
        bus.wb_valid = 1'b0;
        #2 nRST = 1'b0;
        #1;
        check("arst_occ", bus.occupancy, 0);
        check("arst_wen", bus.rf_wen, 1'b0);
        check("arst_ready", bus.output_ready, 1'b1);
        check("arst_sb", bus.sb_done, 1'b0);
        md.delete();
        mv.delete();
        exp_sbd = 1'b0;
        exp_sbv = '0;
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b1);

        // duplicate destinations retire independently and in order
        sb_log.delete();
        cyc(1'b1, rnd512(), 8'h07, 1'b0);
        cyc(1'b1, rnd512(), 8'h07, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, '0, 1'b1);
        check("dup_sb_cnt", sb_log.size(), 2);
        check("dup_sb0", sb_log[0], 8'h07);
        check("dup_sb1", sb_log[1], 8'h07);

        // randomized traffic
        for (int i = 0; i < 500; i++)
            cyc(1'($urandom_range(0, 2) != 0), rnd512(), 8'($urandom_range(0, 15)), 1'($urandom_range(0, 2) != 0));
        for (int i = 0; i < 6; i++) cyc(1'b0, '0, '0, 1'b1);
        compare();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gsau_wb_buffer.md
Name: gsau_wb_buffer

Overview:
- Writeback buffer on the receiving end of the GSAU writeback channel (`psum`/`wbdst`/`wb_valid` in, `output_ready` out).
- Queues partial-sum results from the GSAU and drains them, in order, into the vector register file write port.
- On each retirement, raises a one-cycle completion to the scoreboard so the destination register's pending state clears.

Parameters:
- DEPTH, 4, number of buffered entries; power of two, ≥2.
- DATA_W, 512, width of one psum vector.
- DST_W, 8, width of a destination vector register index.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- psum  input  DATA_W  partial-sum vector from GSAU.
- wbdst  input  DST_W  destination register for psum.
- wb_valid  input  1  GSAU offers psum/wbdst.
- output_ready  output  1  buffer can accept an entry this cycle.
- rf_wen  output  1  write request to register file.
- rf_wdata  output  DATA_W  write data (head entry).
- rf_wdst  output  DST_W  write destination (head entry).
- rf_ready  input  1  register file accepts write this cycle.
- sb_done  output  1  one-cycle pulse: a write retired.
- sb_done_vdst  output  DST_W  register index retired.
- occupancy  output  $clog2(DEPTH+1)  current entry count.

Behaviour:
- Reset is asynchronous, active-low; one clock, CLK.
- Reset values:
  - rd/wr pointers = 0, count = 0.
  - rf_wen = 0, sb_done = 0, sb_done_vdst = 0, occupancy = 0.
  - output_ready = 1 (empty).
  - rf_wdata/rf_wdst = 0 (storage contents are don't-care).
- push = wb_valid && output_ready; pop = rf_wen && rf_ready.
- output_ready = (count != DEPTH), combinational from registered count; no dependence on wb_valid or rf_ready.
- rf_wen = (count != 0); rf_wdata/rf_wdst = entry at rd pointer, combinational from registered state.
- Latency: an entry pushed at edge N is presented on rf_* from N+1 onward. No same-cycle bypass.
- Handshakes:
  - Producer holds psum/wbdst stable while wb_valid && !output_ready; the buffer ignores the offer, and nothing is lost or flagged.
  - rf_* stay stable while rf_wen && !rf_ready.
- Pointers increment modulo DEPTH and wrap from DEPTH-1 to 0.
- count updates:
  - +1 on push only.
  - −1 on pop only.
  - unchanged on push and pop together.
- Full boundary: with count == DEPTH, output_ready = 0, so no push is possible. A pop that cycle makes output_ready = 1 on the next cycle.
- Empty boundary: with count == 0, rf_wen = 0 and rf_ready is ignored. A simultaneous wb_valid pushes normally; pop is impossible.
- Completion: sb_done and sb_done_vdst are registered.
  - sb_done = 1 and sb_done_vdst = head wbdst in the cycle after each pop.
  - Otherwise sb_done = 0 and sb_done_vdst holds its last value.
- Back-to-back pops give sb_done high on consecutive cycles, each carrying the correct vdst.
- Ordering is strictly FIFO. Duplicate wbdst values are legal, are stored independently, and retire in order.
- Reset mid-operation discards all entries immediately. No sb_done is produced for discarded entries.
- occupancy = count.

Decomposition:
- sys_arr_pkg holds:
  - WB_DEPTH (=4) and the DATA_W/DST_W defaults.
  - wb_entry_t, a packed struct {vreg_t data; logic [DST_W-1:0] vdst}.
  - sb_vdst_t.
- One natural sub-module: sync_fifo, parameterised on width and depth. It provides push/pop, full/empty and count, and holds wb_entry_t.
- gsau_wb_buffer wraps sync_fifo, maps the valid/ready handshakes onto it, and adds the sb_done register stage.

Test Plan:
- Reset then single entry:
  - Release nRST, then wb_valid=1, psum=512'hA5…A5, wbdst=8'h03 for one cycle, rf_ready=1.
  - Required: rf_wen=1 with that data/dst exactly one cycle after the push.
  - Required: sb_done=1, sb_done_vdst=8'h03 the following cycle; occupancy returns to 0.
- Fill to full:
  - rf_ready=0; push vdst 1,2,3,4 on consecutive cycles.
  - Required: output_ready=0 after the 4th push and occupancy=4.
  - Required: a 5th offer (vdst 5) is not accepted while output_ready=0.
  - Then rf_ready=1: the file receives 1,2,3,4,5 in order and sb_done pulses 5 times.
- Simultaneous push/pop at full:
  - count=4, wb_valid=1, rf_ready=1.
  - Required: only the pop occurs; occupancy=3 and output_ready=1 next cycle.
  - Then continuous push+pop for 10 cycles holds occupancy at 3, with pointers wrapping twice and order preserved.
- Register-file backpressure:
  - 2 entries queued, rf_ready toggles 0,1,0,1.
  - Required: rf_wdata/rf_wdst stay stable during the 0 cycles; exactly 2 sb_done pulses, in order.
- Reset mid-operation:
  - 3 entries queued, rf_ready=0; assert nRST low mid-cycle (asynchronous to CLK).
  - Required: occupancy=0, rf_wen=0, output_ready=1, sb_done=0 immediately.
  - Required: no stale entry appears after release.
- Duplicate destinations: push wbdst 8'h07 twice.
  - Required: two writes to 8'h07 in push order; two sb_done pulses, both with vdst 8'h07.
